// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx byte serializer between N_SRC byte-stream sources.
// Round-robin arbitration at packet granularity: a granted source keeps
// the link until it sends a beat with tlast, or until MAX_PKT_LEN beats have
// moved (0 disables the limit). The data path is a pure combinational mux.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high (also gates valid/ready)
//   s_axis_tdata   source bytes, source i in bits [8i+7:8i]
//   s_axis_tvalid  per-source valid
//   s_axis_tlast   per-source end-of-message flag
//   s_axis_tready  per-source ready
//   m_axis_tdata   byte to uart_tx
//   m_axis_tvalid  valid to uart_tx
//   m_axis_tready  ready from uart_tx
//   grant_id       currently or last granted source
//   busy           high while a grant is held
//
// state  | meaning
// IDLE   | no grant held; pick next requester from rr_ptr upward
// LOCKED | grant_id owns the link until tlast or beat limit

module uart_tx_arbiter #(
   parameter int N_SRC       = 4,
   parameter int MAX_PKT_LEN = 64,
   parameter int GID_W       = $clog2(N_SRC)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*N_SRC-1:0]   s_axis_tdata,
   input  logic [N_SRC-1:0]     s_axis_tvalid,
   input  logic [N_SRC-1:0]     s_axis_tlast,
   output logic [N_SRC-1:0]     s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [GID_W-1:0]     grant_id,
   output logic                 busy
);

   localparam int CNT_W_RAW = $clog2(MAX_PKT_LEN + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
   localparam int LIMIT_I   = (MAX_PKT_LEN > 0) ? MAX_PKT_LEN - 1 : 0;
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT_I);
   localparam logic [GID_W-1:0] LAST_ID  = GID_W'(N_SRC - 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            state, state_next;
   logic [GID_W-1:0]  rr_ptr, rr_next, grant_next, sel_id;
   logic [CNT_W-1:0]  beat_cnt, cnt_next;
   logic              sel_found;
   logic              sel_valid, sel_last;
   logic [7:0]        sel_data;
   logic              xfer, release_now;
   int                cand;

   // Mux of the granted source's stream.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = 8'h00;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_id == GID_W'(i)) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_data  = s_axis_tdata[8*i +: 8];
         end
      end
   end

   // Round-robin search: walk offsets from the far end down to 0 so the
   // smallest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      cand      = 0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= N_SRC) cand = cand - N_SRC;
         for (int j = 0; j < N_SRC; j++) begin
            if (j == cand && s_axis_tvalid[j]) begin
               sel_found = 1'b1;
               sel_id    = GID_W'(j);
            end
         end
      end
   end

   always_comb begin
      state_next    = state;
      grant_next    = grant_id;
      rr_next       = rr_ptr;
      cnt_next      = beat_cnt;
      busy          = (state == S_LOCKED);
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      s_axis_tready = '0;
      xfer          = 1'b0;
      release_now   = 1'b0;
      case (state)
         S_IDLE: begin
            if (sel_found) begin
               state_next = S_LOCKED;
               grant_next = sel_id;
               cnt_next   = '0;
            end
         end
         S_LOCKED: begin
            m_axis_tdata  = sel_data;
            m_axis_tvalid = sel_valid & ~rst;
            for (int i = 0; i < N_SRC; i++) begin
               if (grant_id == GID_W'(i)) s_axis_tready[i] = m_axis_tready & ~rst;
            end
            xfer = m_axis_tvalid & m_axis_tready;
            if (xfer) begin
               cnt_next    = beat_cnt + 1'b1;
               release_now = sel_last || ((MAX_PKT_LEN != 0) && (beat_cnt == LIMIT_M1));
               if (release_now) begin
                  state_next = S_IDLE;
                  cnt_next   = '0;
                  rr_next    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_next;
         rr_ptr   <= rr_next;
         grant_id <= grant_next;
         beat_cnt <= cnt_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tvalid;
   logic [3:0]  s_axis_tlast;
   logic [3:0]  s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [1:0]  grant_id;
   logic        busy;

   uart_tx_arbiter #(.N_SRC(4), .MAX_PKT_LEN(4), .GID_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // per-source byte queues: {tlast, data}
   logic [8:0] mem [4][16];
   int         wr [4];
   int         rd [4];
   logic       en [4];
   int         rdy_period;
   int         cyc;

   // transfers seen on the master side
   int         log_n;
   int         log_g [64];
   logic [7:0] log_d [64];
   int         log_c [64];
   logic       log_b [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_srcs();
      for (int i = 0; i < 4; i++) begin
         wr[i] = 0; rd[i] = 0; en[i] = 1'b1;
      end
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      mem[s][wr[s]] = {l, d};
      wr[s]++;
   endtask

   task automatic drive_settle();
      for (int i = 0; i < 4; i++) begin
         if (en[i] && rd[i] < wr[i]) begin
            s_axis_tvalid[i]      = 1'b1;
            s_axis_tdata[8*i +: 8] = mem[i][rd[i]][7:0];
            s_axis_tlast[i]       = mem[i][rd[i]][8];
         end else begin
            s_axis_tvalid[i]      = 1'b0;
            s_axis_tdata[8*i +: 8] = 8'h00;
            s_axis_tlast[i]       = 1'b0;
         end
      end
      m_axis_tready = (rdy_period == 0) ? 1'b1 : ((cyc % rdy_period) == 0);
      #1;
   endtask

   task automatic finish_cycle();
      if (m_axis_tvalid && m_axis_tready && log_n < 64) begin
         log_g[log_n] = int'(grant_id);
         log_d[log_n] = m_axis_tdata;
         log_c[log_n] = cyc;
         log_b[log_n] = busy;
         log_n++;
      end
      for (int i = 0; i < 4; i++)
         if (s_axis_tvalid[i] && s_axis_tready[i]) rd[i]++;
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic cycle();
      drive_settle();
      finish_cycle();
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (log_n < n && k < budget) begin
         cycle();
         k++;
      end
      check({tag, "_count"}, 32'(log_n), 32'(n));
   endtask

   task automatic exp_beat(input string tag, input int idx, input int g, input logic [7:0] d);
      check($sformatf("%s_gid%0d", tag, idx), 32'(log_g[idx]), 32'(g));
      check($sformatf("%s_data%0d", tag, idx), 32'(log_d[idx]), 32'(d));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      clear_srcs();
      log_n = 0;
   endtask

   int bad_v, bad_r, bad_b, bad_g;

   initial begin
      s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
      m_axis_tready = 1'b0; rst = 1'b1; cyc = 0; log_n = 0; rdy_period = 0;
      clear_srcs();

      // ---- reset gating with every source requesting ----
      for (int i = 0; i < 4; i++) push(i, 8'hF0, 1'b1);
      @(posedge clk); #2;
      drive_settle();
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      finish_cycle();
      rst = 1'b0;
      clear_srcs();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_gid", 32'(grant_id), 32'd0);

      // ---- idle for 20 cycles ----
      bad_v = 0; bad_r = 0; bad_b = 0; bad_g = 0;
      for (int i = 0; i < 20; i++) begin
         drive_settle();
         if (m_axis_tvalid !== 1'b0) bad_v++;
         if (s_axis_tready !== 4'h0) bad_r++;
         if (busy !== 1'b0) bad_b++;
         if (grant_id !== 2'd0 || m_axis_tdata !== 8'h00) bad_g++;
         finish_cycle();
      end
      check("idle_tvalid_cycles", 32'(bad_v), 32'd0);
      check("idle_tready_cycles", 32'(bad_r), 32'd0);
      check("idle_busy_cycles", 32'(bad_b), 32'd0);
      check("idle_gid_tdata_cycles", 32'(bad_g), 32'd0);

      // ---- single packet from src2, ready 1 cycle in 10 ----
      log_n = 0; rdy_period = 10;
      push(2, 8'h48, 1'b0); push(2, 8'h69, 1'b0); push(2, 8'h0A, 1'b1);
      run_until(3, 200, "single");
      exp_beat("single", 0, 2, 8'h48);
      exp_beat("single", 1, 2, 8'h69);
      exp_beat("single", 2, 2, 8'h0A);
      check("single_busy_at_last", 32'(log_b[2]), 32'd1);
      check("single_busy_after", 32'(busy), 32'd0);
      check("single_gid_held", 32'(grant_id), 32'd2);

      // rr_ptr is now 3: src3 beats src0
      rdy_period = 0;
      push(0, 8'h11, 1'b1); push(3, 8'h33, 1'b1);
      run_until(5, 50, "rr3");
      exp_beat("rr3", 3, 3, 8'h33);
      exp_beat("rr3", 4, 0, 8'h11);

      // ---- round robin, all sources, 2-byte packets ----
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(i, 8'(i*16 + 1), 1'b0);
         push(i, 8'(i*16 + 2), 1'b1);
      end
      push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
      run_until(10, 100, "rr");
      exp_beat("rr", 0, 0, 8'h01); exp_beat("rr", 1, 0, 8'h02);
      exp_beat("rr", 2, 1, 8'h11); exp_beat("rr", 3, 1, 8'h12);
      exp_beat("rr", 4, 2, 8'h21); exp_beat("rr", 5, 2, 8'h22);
      exp_beat("rr", 6, 3, 8'h31); exp_beat("rr", 7, 3, 8'h32);
      exp_beat("rr", 8, 0, 8'h03); exp_beat("rr", 9, 0, 8'h04);
      for (int p = 0; p < 5; p++)
         check($sformatf("rr_inpkt_gap%0d", p), 32'(log_c[2*p+1] - log_c[2*p]), 32'd1);
      for (int p = 1; p < 5; p++)
         check($sformatf("rr_dead_gap%0d", p), 32'(log_c[2*p] - log_c[2*p-1]), 32'd2);

      // ---- beat limit 4: src1 without tlast, src3 competing ----
      do_reset();
      for (int i = 0; i < 10; i++) push(1, 8'(8'h50 + i), 1'b0);
      push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b1);
      run_until(12, 100, "lim");
      for (int i = 0; i < 4; i++) exp_beat("lim", i, 1, 8'(8'h50 + i));
      exp_beat("lim", 4, 3, 8'hC0);
      exp_beat("lim", 5, 3, 8'hC1);
      for (int i = 0; i < 6; i++) exp_beat("lim", 6 + i, 1, 8'(8'h54 + i));

      // ---- reset mid-packet ----
      log_n = 0;
      push(1, 8'h5A, 1'b1);               // closes src1's open grant, rr_ptr -> 2
      run_until(1, 20, "mid_close");
      exp_beat("mid_close", 0, 1, 8'h5A);
      for (int i = 1; i <= 5; i++) push(0, 8'(i), (i == 5));
      run_until(3, 20, "mid_pre");
      exp_beat("mid_pre", 1, 0, 8'h01);
      exp_beat("mid_pre", 2, 0, 8'h02);
      rst = 1'b1;
      drive_settle();
      check("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
      finish_cycle();
      rst = 1'b0;
      check("mid_post_busy", 32'(busy), 32'd0);
      check("mid_post_gid", 32'(grant_id), 32'd0);
      push(2, 8'hEE, 1'b1);
      run_until(7, 50, "mid_post");
      exp_beat("mid_post", 3, 0, 8'h03);
      exp_beat("mid_post", 4, 0, 8'h04);
      exp_beat("mid_post", 5, 0, 8'h05);
      exp_beat("mid_post", 6, 2, 8'hEE);

      // ---- stall: src2 drops tvalid mid-packet while src0 waits ----
      log_n = 0;
      push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b0); push(2, 8'h73, 1'b1);
      run_until(1, 20, "stall_pre");
      en[2] = 1'b0;
      push(0, 8'h0F, 1'b1);
      bad_v = 0; bad_r = 0; bad_b = 0; bad_g = 0;
      for (int i = 0; i < 50; i++) begin
         drive_settle();
         if (m_axis_tvalid !== 1'b0) bad_v++;
         if (s_axis_tready[0] !== 1'b0) bad_r++;
         if (busy !== 1'b1) bad_b++;
         if (grant_id !== 2'd2) bad_g++;
         finish_cycle();
      end
      check("stall_tvalid_cycles", 32'(bad_v), 32'd0);
      check("stall_src0_ready_cycles", 32'(bad_r), 32'd0);
      check("stall_busy_cycles", 32'(bad_b), 32'd0);
      check("stall_gid_cycles", 32'(bad_g), 32'd0);
      en[2] = 1'b1;
      run_until(4, 50, "stall");
      exp_beat("stall", 0, 2, 8'h71);
      exp_beat("stall", 1, 2, 8'h72);
      exp_beat("stall", 2, 2, 8'h73);
      exp_beat("stall", 3, 0, 8'h0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
